// File: rtl/imem_responder_pkg.sv
// Shared processor definitions: fetch-responder FSM encoding and the NOP word.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } imem_state_t;

    // Word returned for fetches outside the loaded program.
    localparam logic [15:0] IMEM_NOP = 16'h0000;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port, no reset.
module imem_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port and read port; the read register holds while i_re is low.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: accepts a program from a loader, then serves
// fetches with one cycle of latency, returning NOP beyond the loaded length.
// Loader handshake: a beat transfers on a rising edge where load_valid_i and
// load_ready_o are both high; load_ready_o depends on state only.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] im_addr_i,
    input  logic                  im_rd_i,
    output logic [DATA_WIDTH-1:0] im_data_o,
    output logic                  im_valid_o,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_ready_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic                  busy_o,
    output imem_state_t           dbg_state_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    imem_state_t           r_state;
    imem_state_t           w_next_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic                  r_done;
    logic                  r_err;
    logic                  r_valid;
    logic                  r_zero;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_idle;
    logic                  w_len_ok;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_hit;

    // Load control decode and next-state selection.
    always_comb begin
        w_next_state = r_state;
        w_idle       = (r_state != S_LOAD);
        w_len_ok     = (load_len_i != '0) && (load_len_i <= DEPTH);
        w_start_ok   = load_start_i && w_idle && w_len_ok;
        w_start_bad  = load_start_i && w_idle && !w_len_ok;
        w_beat       = load_valid_i && (r_state == S_LOAD);
        w_last       = w_beat && (r_wr_ptr == r_len - 1'b1);
        // A fetch hits only in S_READY, inside the program, and not in the
        // cycle a reload is accepted (the reload hides the old program).
        w_hit        = (r_state == S_READY) && !w_start_ok &&
                       ({1'b0, im_addr_i} < r_len);
        case (r_state)
            S_EMPTY, S_READY: if (w_start_ok) w_next_state = S_LOAD;
            S_LOAD:           if (w_last)     w_next_state = S_READY;
            default:          w_next_state = S_EMPTY;
        endcase
    end

    // State register plus load bookkeeping and completion/error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_EMPTY;
            r_len    <= '0;
            r_wr_ptr <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last;
            r_err   <= w_start_bad;
            if (w_start_ok) begin
                r_len    <= load_len_i;
                r_wr_ptr <= '0;
            end else if (w_beat) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Fetch response flags; r_zero forces NOP and holds with the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            r_valid <= im_rd_i && (r_state == S_READY) && !w_start_ok;
            if (im_rd_i) begin
                r_zero <= !w_hit;
            end
        end
    end

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_beat),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (load_data_i),
        .i_re    (im_rd_i),
        .i_raddr (im_addr_i),
        .o_rdata (w_rd_data)
    );

    assign im_data_o    = r_zero ? DATA_WIDTH'(IMEM_NOP) : w_rd_data;
    assign im_valid_o   = r_valid;
    assign load_ready_o = (r_state == S_LOAD);
    assign busy_o       = (r_state == S_LOAD);
    assign load_done_o  = r_done;
    assign load_err_o   = r_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus a randomized phase, all
// checked every cycle against a behavioural model of the program memory.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] im_addr_i;
    logic          im_rd_i;
    logic [DW-1:0] im_data_o;
    logic          im_valid_o;
    logic          load_start_i;
    logic [AW:0]   load_len_i;
    logic          load_valid_i;
    logic [DW-1:0] load_data_i;
    logic          load_ready_o;
    logic          load_done_o;
    logic          load_err_o;
    logic          busy_o;
    imem_state_t   dbg_state_o;

    always #5 clk = ~clk;

    imem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .im_addr_i    (im_addr_i),
        .im_rd_i      (im_rd_i),
        .im_data_o    (im_data_o),
        .im_valid_o   (im_valid_o),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o),
        .busy_o       (busy_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- reference model ----------------
    // mode: 0 = no program, 1 = loading, 2 = program available
    int            m_mode;
    int            m_len;
    int            m_ptr;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_data;
    bit            m_valid;
    bit            m_done;
    bit            m_err;

    int n_vec;
    int n_err;
    int done_cnt;
    int acc_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_len   = 0;
        m_ptr   = 0;
        m_data  = '0;
        m_valid = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        bit start_ok;
        bit start_bad;
        int len_req;
        len_req   = int'(load_len_i);
        start_ok  = load_start_i && (m_mode != 1) && (len_req >= 1) && (len_req <= DEPTH);
        start_bad = load_start_i && (m_mode != 1) && !((len_req >= 1) && (len_req <= DEPTH));
        if (im_rd_i) begin
            if (m_mode == 2 && !start_ok) begin
                m_valid = 1;
                m_data  = (int'(im_addr_i) < m_len) ? m_mem[im_addr_i] : '0;
            end else begin
                m_valid = 0;
                m_data  = '0;
            end
        end else begin
            m_valid = 0;
        end
        m_done = 0;
        m_err  = start_bad;
        if (m_mode == 1 && load_valid_i) begin
            m_mem[m_ptr] = load_data_i;
            m_ptr++;
            if (m_ptr == m_len) begin
                m_mode = 2;
                m_done = 1;
            end
        end
        if (start_ok) begin
            m_mode = 1;
            m_len  = len_req;
            m_ptr  = 0;
        end
    endtask

    task automatic check_outputs();
        imem_state_t exp_state;
        exp_state = (m_mode == 0) ? S_EMPTY : (m_mode == 1) ? S_LOAD : S_READY;
        check_eq("im_data",  32'(im_data_o),    32'(m_data));
        check_eq("im_valid", 32'(im_valid_o),   32'(m_valid));
        check_eq("ready",    32'(load_ready_o), 32'(m_mode == 1));
        check_eq("busy",     32'(busy_o),       32'(m_mode == 1));
        check_eq("done",     32'(load_done_o),  32'(m_done));
        check_eq("err",      32'(load_err_o),   32'(m_err));
        check_eq("state",    32'(dbg_state_o),  32'(exp_state));
    endtask

    // One clock: model and DUT advance together, outputs checked 1ns later.
    task automatic step();
        if (load_valid_i && load_ready_o) acc_cnt++;
        model_clock();
        @(posedge clk);
        #1;
        if (load_done_o) done_cnt++;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        im_addr_i    = '0;
        im_rd_i      = 1'b0;
        load_start_i = 1'b0;
        load_len_i   = '0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_eq("rst_data",  32'(im_data_o),    32'h0);
        check_eq("rst_valid", 32'(im_valid_o),   32'h0);
        check_eq("rst_ready", 32'(load_ready_o), 32'h0);
        check_eq("rst_done",  32'(load_done_o),  32'h0);
        check_eq("rst_err",   32'(load_err_o),   32'h0);
        check_eq("rst_busy",  32'(busy_o),       32'h0);
        check_eq("rst_state", 32'(dbg_state_o),  32'(S_EMPTY));
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic start_load(input int len);
        load_start_i = 1'b1;
        load_len_i   = (AW+1)'(len);
        step();
        load_start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] data);
        load_valid_i = 1'b1;
        load_data_i  = data;
        step();
        load_valid_i = 1'b0;
    endtask

    task automatic read_word(input int addr);
        im_rd_i   = 1'b1;
        im_addr_i = AW'(addr);
        step();
        im_rd_i   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [DW-1:0] last_word;
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b0;
        #2;
        do_reset();

        // Three-word program, fetch from inside and outside it.
        done_cnt = 0;
        start_load(3);
        send_beat(16'h1111);
        send_beat(16'h2222);
        send_beat(16'h3333);
        step();
        step();
        check_eq("done_once_len3", 32'(done_cnt), 32'd1);
        read_word(1);
        check_eq("rd_addr1_data",  32'(im_data_o),  32'h2222);
        check_eq("rd_addr1_valid", 32'(im_valid_o), 32'h1);
        read_word(7);
        check_eq("rd_addr7_nop",   32'(im_data_o),  32'h0000);
        check_eq("rd_addr7_valid", 32'(im_valid_o), 32'h1);
        step();
        check_eq("rd_low_valid",   32'(im_valid_o), 32'h0);

        // Rejected lengths leave the loaded program alone.
        start_load(0);
        check_eq("err_len0",       32'(load_err_o),  32'h1);
        check_eq("err_len0_state", 32'(dbg_state_o), 32'(S_READY));
        step();
        start_load(257);
        check_eq("err_len257",       32'(load_err_o),  32'h1);
        check_eq("err_len257_state", 32'(dbg_state_o), 32'(S_READY));
        read_word(2);
        check_eq("len_kept_data", 32'(im_data_o), 32'h3333);

        // Loader with a gappy valid; done only after the fourth beat.
        done_cnt = 0;
        acc_cnt  = 0;
        start_load(4);
        for (int i = 0; i < 8; i++) begin
            load_valid_i = (i % 2 == 0);
            load_data_i  = DW'(16'h4000 + i);
            im_rd_i      = 1'b1;
            im_addr_i    = AW'(i % 4);
            if (i == 6) begin
                step();
                check_eq("done_after_4th", 32'(load_done_o), 32'h1);
            end else begin
                step();
            end
        end
        idle_inputs();
        check_eq("toggle_writes", 32'(acc_cnt),  32'd4);
        check_eq("toggle_done",   32'(done_cnt), 32'd1);
        for (int a = 0; a < 5; a++) read_word(a);

        // Reset in the middle of a load, then a fresh one-word load.
        start_load(5);
        send_beat(16'h5555);
        send_beat(16'h6666);
        do_reset();
        start_load(1);
        send_beat(16'hABCD);
        step();
        read_word(0);
        check_eq("after_abort_addr0", 32'(im_data_o), 32'hABCD);
        read_word(1);
        check_eq("after_abort_addr1", 32'(im_data_o), 32'h0000);

        // Full-depth load.
        done_cnt = 0;
        start_load(DEPTH);
        last_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last_word = DW'($urandom);
            send_beat(last_word);
        end
        step();
        check_eq("full_done", 32'(done_cnt), 32'd1);
        read_word(255);
        check_eq("full_last_word", 32'(im_data_o), 32'(last_word));

        // Randomized traffic: loads, rejects, reloads, fetches, rare resets.
        for (int c = 0; c < 1500; c++) begin
            int r;
            load_start_i = ($urandom_range(0, 15) == 0);
            r = int'($urandom_range(0, 24));
            load_len_i   = (r > 20) ? (AW+1)'(257 + r) : (AW+1)'(r);
            load_valid_i = $urandom_range(0, 1) == 1;
            load_data_i  = DW'($urandom);
            im_rd_i      = $urandom_range(0, 1) == 1;
            im_addr_i    = AW'($urandom_range(0, 24));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
